// File: rtl/spi_input_conditioner.sv
// Pin conditioning for the SPI slave: two-flop synchronizer, per-channel debounce
// counter and registered edge strobes for SCLK, CS and MOSI.
module spi_input_conditioner #(
    parameter int WAIT_TIME     = 3,
    parameter int COUNTER_WIDTH = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic sclk_pin,
    input  logic cs_pin,
    input  logic mosi_pin,
    output logic sclk_conditioned,
    output logic sclk_positiveedge,
    output logic sclk_negativeedge,
    output logic cs_conditioned,
    output logic cs_negativeedge,
    output logic mosi_conditioned
);

    localparam int unsigned NCH = 3;
    localparam int unsigned CH_SCLK = 0;
    localparam int unsigned CH_CS   = 1;
    localparam int unsigned CH_MOSI = 2;

    // CS idles high (deselected); SCLK and MOSI idle low.
    localparam logic [NCH-1:0] RESET_LEVEL = 3'b010;
    localparam logic [COUNTER_WIDTH-1:0] WAIT_COUNT = COUNTER_WIDTH'(WAIT_TIME);

    logic [NCH-1:0]           pins;
    logic [NCH-1:0]           sync0;
    logic [NCH-1:0]           sync1;
    logic [NCH-1:0]           level;
    logic [NCH-1:0]           accept;
    logic [COUNTER_WIDTH-1:0] count      [NCH];
    logic [COUNTER_WIDTH-1:0] count_next [NCH];
    logic                     sclk_pos_q;
    logic                     sclk_neg_q;
    logic                     cs_neg_q;

    assign pins = {mosi_pin, cs_pin, sclk_pin};

    always_comb begin
        accept = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            count_next[i] = '0;
            if (sync1[i] != level[i]) begin
                if (count[i] == WAIT_COUNT) begin
                    accept[i] = 1'b1;
                end else begin
                    count_next[i] = count[i] + COUNTER_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync0      <= RESET_LEVEL;
            sync1      <= RESET_LEVEL;
            level      <= RESET_LEVEL;
            sclk_pos_q <= 1'b0;
            sclk_neg_q <= 1'b0;
            cs_neg_q   <= 1'b0;
            for (int unsigned i = 0; i < NCH; i++) begin
                count[i] <= '0;
            end
        end else begin
            sync0 <= pins;
            sync1 <= sync0;
            // Acceptance only happens on a mismatch, so it is a toggle of the level.
            level      <= level ^ accept;
            sclk_pos_q <= accept[CH_SCLK] & sync1[CH_SCLK];
            sclk_neg_q <= accept[CH_SCLK] & ~sync1[CH_SCLK];
            cs_neg_q   <= accept[CH_CS] & ~sync1[CH_CS];
            for (int unsigned i = 0; i < NCH; i++) begin
                count[i] <= count_next[i];
            end
        end
    end

    assign sclk_conditioned  = level[CH_SCLK];
    assign cs_conditioned    = level[CH_CS];
    assign mosi_conditioned  = level[CH_MOSI];
    assign sclk_positiveedge = sclk_pos_q;
    assign sclk_negativeedge = sclk_neg_q;
    assign cs_negativeedge   = cs_neg_q;

endmodule

// File: tb/tb_spi_input_conditioner.sv
// Self-checking bench for spi_input_conditioner: directed timing scenarios plus
// randomized pin activity compared against a sliding-window reference model.
module tb_spi_input_conditioner;

    localparam int W = 3;
    localparam logic [2:0] RST = 3'b010;          // {mosi, cs, sclk}
    localparam logic [5:0] RST_OUT = 6'b000100;   // {sclk_c, spos, sneg, cs_c, cneg, mosi_c}

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sclk_pin = 1'b0;
    logic cs_pin = 1'b1;
    logic mosi_pin = 1'b0;
    logic sclk_conditioned, sclk_positiveedge, sclk_negativeedge;
    logic cs_conditioned, cs_negativeedge, mosi_conditioned;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    spi_input_conditioner #(.WAIT_TIME(W), .COUNTER_WIDTH(3)) dut (
        .clk(clk),
        .reset(reset),
        .sclk_pin(sclk_pin),
        .cs_pin(cs_pin),
        .mosi_pin(mosi_pin),
        .sclk_conditioned(sclk_conditioned),
        .sclk_positiveedge(sclk_positiveedge),
        .sclk_negativeedge(sclk_negativeedge),
        .cs_conditioned(cs_conditioned),
        .cs_negativeedge(cs_negativeedge),
        .mosi_conditioned(mosi_conditioned)
    );

    wire [5:0] dut_out = {sclk_conditioned, sclk_positiveedge, sclk_negativeedge,
                          cs_conditioned, cs_negativeedge, mosi_conditioned};

    // Reference: a channel flips when the last W+1 synchronized samples (pin samples
    // taken two or more edges ago) all differ from its current level.
    logic [2:0] hist [$];
    logic [2:0] m_level;
    logic m_spos, m_sneg, m_cneg;

    always @(posedge clk or posedge reset) begin : model
        logic [2:0] acc;
        logic [2:0] nxt;
        if (reset) begin
            hist.delete();
            for (int i = 0; i < W + 2; i++) hist.push_back(RST);
            m_level <= RST;
            m_spos  <= 1'b0;
            m_sneg  <= 1'b0;
            m_cneg  <= 1'b0;
        end else begin
            acc = 3'b111;
            for (int j = 0; j <= W; j++) acc = acc & (hist[hist.size() - 2 - j] ^ m_level);
            nxt = m_level ^ acc;
            m_level <= nxt;
            m_spos  <= acc[0] & nxt[0];
            m_sneg  <= acc[0] & ~nxt[0];
            m_cneg  <= acc[1] & ~nxt[1];
            hist.push_back({mosi_pin, cs_pin, sclk_pin});
            void'(hist.pop_front());
        end
    end

    wire [5:0] model_out = {m_level[0], m_spos, m_sneg, m_level[1], m_cneg, m_level[2]};

    task automatic test_reset;
        sclk_pin = 1'b0; cs_pin = 1'b1; mosi_pin = 1'b0; reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (dut_out !== RST_OUT) begin
            errors++; $display("FAIL reset_hold got %b want %b", dut_out, RST_OUT);
        end
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (dut_out !== RST_OUT) begin
                errors++; $display("FAIL reset_idle cycle %0d got %b want %b", i, dut_out, RST_OUT);
            end
        end
        sclk_pin = 1'b1; cs_pin = 1'b0; mosi_pin = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if ({sclk_conditioned, cs_conditioned, mosi_conditioned} !== 3'b101) begin
            errors++;
            $display("FAIL reset_prelevels got %b want 101",
                     {sclk_conditioned, cs_conditioned, mosi_conditioned});
        end
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        checks++;
        if (dut_out !== RST_OUT) begin
            errors++; $display("FAIL reset_async got %b want %b", dut_out, RST_OUT);
        end
        sclk_pin = 1'b0; cs_pin = 1'b1; mosi_pin = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_clean_edge;
        logic [2:0] got, exp;
        @(negedge clk);
        sclk_pin = 1'b1;
        @(posedge clk);
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            got = {sclk_conditioned, sclk_positiveedge, sclk_negativeedge};
            exp = {(k >= W + 2), (k == W + 2), 1'b0};
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL clean_rise k=%0d got %b want %b", k, got, exp);
            end
        end
        sclk_pin = 1'b0;
        @(posedge clk);
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            got = {sclk_conditioned, sclk_positiveedge, sclk_negativeedge};
            exp = {(k < W + 2), 1'b0, (k == W + 2)};
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL clean_fall k=%0d got %b want %b", k, got, exp);
            end
        end
    endtask

    task automatic test_glitch(input int len);
        logic exp;
        @(negedge clk);
        mosi_pin = 1'b1;
        @(posedge clk);
        for (int k = 0; k <= 14; k++) begin
            @(negedge clk);
            exp = (len >= W + 1) && (k >= W + 2) && (k < len + W + 2);
            checks++;
            if (mosi_conditioned !== exp) begin
                errors++;
                $display("FAIL glitch len=%0d k=%0d got %b want %b", len, k, mosi_conditioned, exp);
            end
            if (k == len - 1) mosi_pin = 1'b0;
        end
    endtask

    task automatic test_bounce;
        localparam int F = 6;
        int strobes;
        logic [1:0] got, exp;
        strobes = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            got = {cs_conditioned, cs_negativeedge};
            exp = {(i < F + W + 3), (i == F + W + 3)};
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL bounce i=%0d got %b want %b", i, got, exp);
            end
            if (cs_negativeedge === 1'b1) strobes++;
            cs_pin = (i < F) ? ~((i / 2) % 2 == 1) : 1'b0;
        end
        checks++;
        if (strobes != 1) begin
            errors++; $display("FAIL bounce_count got %0d want 1", strobes);
        end
    endtask

    task automatic test_simultaneous;
        logic [1:0] got, exp;
        cs_pin = 1'b1;
        repeat (10) @(negedge clk);
        cs_pin = 1'b0; sclk_pin = 1'b1;
        @(posedge clk);
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            got = {cs_negativeedge, sclk_positiveedge};
            exp = {2{k == W + 2}};
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL simultaneous k=%0d got %b want %b", k, got, exp);
            end
        end
        sclk_pin = 1'b0; cs_pin = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        logic [2:0] got, exp;
        @(negedge clk);
        sclk_pin = 1'b1;
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (dut_out !== RST_OUT) begin
            errors++; $display("FAIL resetmid_assert got %b want %b", dut_out, RST_OUT);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (dut_out !== RST_OUT) begin
                errors++; $display("FAIL resetmid_hold i=%0d got %b want %b", i, dut_out, RST_OUT);
            end
        end
        reset = 1'b0;
        @(posedge clk);
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            got = {sclk_conditioned, sclk_positiveedge, sclk_negativeedge};
            exp = {(k >= W + 2), (k == W + 2), 1'b0};
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL resetmid_release k=%0d got %b want %b", k, got, exp);
            end
        end
        sclk_pin = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_random;
        int run [3];
        logic [2:0] pv;
        int hold;
        pv = {mosi_pin, cs_pin, sclk_pin};
        run = '{0, 0, 0};
        hold = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(negedge clk);
            checks++;
            if (dut_out !== model_out) begin
                errors++; $display("FAIL random cycle %0d got %b want %b", cyc, dut_out, model_out);
            end
            if (reset) begin
                hold--;
                if (hold == 0) reset = 1'b0;
            end else if ($urandom_range(0, 199) == 0) begin
                #2 reset = 1'b1;
                hold = 2;
            end
            for (int c = 0; c < 3; c++) begin
                if (run[c] == 0) begin
                    pv[c] = ~pv[c];
                    run[c] = $urandom_range(1, 8);
                end
                run[c]--;
            end
            sclk_pin = pv[0]; cs_pin = pv[1]; mosi_pin = pv[2];
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_clean_edge();
        test_glitch(3);
        test_glitch(4);
        test_bounce();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
